// File: rtl/window_streamer_if.sv
// Valid/ready pixel stream carrying one window beat per transfer.
// The master side produces beats; the slave side consumes them and drives out_ready.
interface window_streamer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_first;
  logic                  out_last;
  logic                  out_eof;

  modport master (
    output out_valid, out_data, out_first, out_last, out_eof,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_first, out_last, out_eof,
    output out_ready
  );
endinterface

// File: rtl/window_streamer.sv
// K x K sliding-window streamer: walks wy, wx, ch, kr, kc over a preloaded
// multi-channel image and emits one pixel per accepted valid/ready beat.
module window_streamer #(
  parameter  int IMG_W      = 5,
  parameter  int IMG_H      = 5,
  parameter  int DATA_WIDTH = 8,
  parameter  int KERNEL     = 3,
  parameter  int STRIDE     = 1,
  parameter  int CHANNELS   = 1,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int PIX_AW     = (IMG_W * IMG_H > 1) ? $clog2(IMG_W * IMG_H) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  preload_en,
  input  logic [CH_W-1:0]       preload_ch,
  input  logic [PIX_AW-1:0]     preload_addr,
  input  logic [DATA_WIDTH-1:0] preload_pixel,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  window_streamer_if.master     strm
);

  localparam int PLANE     = IMG_W * IMG_H;
  localparam int MEM_DEPTH = PLANE * CHANNELS;
  localparam int MEM_AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int OUT_W     = (IMG_W - KERNEL) / STRIDE + 1;
  localparam int OUT_H     = (IMG_H - KERNEL) / STRIDE + 1;
  localparam int K_W       = (KERNEL > 1) ? $clog2(KERNEL) : 1;
  localparam int WX_W      = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int WY_W      = (OUT_H > 1) ? $clog2(OUT_H) : 1;

  localparam logic [K_W-1:0]  K_LAST  = K_W'(KERNEL - 1);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(CHANNELS - 1);
  localparam logic [WX_W-1:0] WX_LAST = WX_W'(OUT_W - 1);
  localparam logic [WY_W-1:0] WY_LAST = WY_W'(OUT_H - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t state_q, state_d;

  logic [WY_W-1:0] wy_q, wy_d;
  logic [WX_W-1:0] wx_q, wx_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [K_W-1:0]  kr_q, kr_d;
  logic [K_W-1:0]  kc_q, kc_d;
  logic            exhausted_q, exhausted_d;

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_first_q, out_first_d;
  logic                  out_last_q, out_last_d;
  logic                  out_eof_q, out_eof_d;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic              kc_end, kr_end, ch_end, wx_end, wy_end, frame_end;
  logic              issue, accept, wr_en;
  logic [MEM_AW-1:0] rd_addr, wr_addr;

  assign kc_end    = (kc_q == K_LAST);
  assign kr_end    = (kr_q == K_LAST);
  assign ch_end    = (ch_q == CH_LAST);
  assign wx_end    = (wx_q == WX_LAST);
  assign wy_end    = (wy_q == WY_LAST);
  assign frame_end = kc_end && kr_end && ch_end && wx_end && wy_end;

  assign accept = out_valid_q && strm.out_ready;
  // Beat 0 is issued on the start edge itself so it is valid one cycle after start.
  assign issue  = !clear
               && ((state_q == IDLE && start) || (state_q == STREAM && !exhausted_q))
               && (!out_valid_q || strm.out_ready);

  // Every partial term stays below MEM_DEPTH, so MEM_AW-wide arithmetic never wraps.
  assign rd_addr = MEM_AW'(ch_q) * MEM_AW'(PLANE)
                 + (MEM_AW'(wy_q) * MEM_AW'(STRIDE) + MEM_AW'(kr_q)) * MEM_AW'(IMG_W)
                 + MEM_AW'(wx_q) * MEM_AW'(STRIDE) + MEM_AW'(kc_q);

  assign wr_addr = MEM_AW'(preload_ch) * MEM_AW'(PLANE) + MEM_AW'(preload_addr);
  assign wr_en   = preload_en && (state_q != STREAM)
                && (32'(preload_ch) < CHANNELS) && (32'(preload_addr) < PLANE);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= preload_pixel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wy_q        <= '0;
      wx_q        <= '0;
      ch_q        <= '0;
      kr_q        <= '0;
      kc_q        <= '0;
      exhausted_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_eof_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wy_q        <= wy_d;
      wx_q        <= wx_d;
      ch_q        <= ch_d;
      kr_q        <= kr_d;
      kc_q        <= kc_d;
      exhausted_q <= exhausted_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      out_eof_q   <= out_eof_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = STREAM;
      STREAM:  if (accept && out_eof_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  // Counters advance innermost-first on every issue; a full frame wraps them back to zero.
  always_comb begin
    wy_d = wy_q;
    wx_d = wx_q;
    ch_d = ch_q;
    kr_d = kr_q;
    kc_d = kc_q;
    if (issue) begin
      kc_d = kc_end ? '0 : kc_q + 1'b1;
      if (kc_end) begin
        kr_d = kr_end ? '0 : kr_q + 1'b1;
        if (kr_end) begin
          ch_d = ch_end ? '0 : ch_q + 1'b1;
          if (ch_end) begin
            wx_d = wx_end ? '0 : wx_q + 1'b1;
            if (wx_end) begin
              wy_d = wy_end ? '0 : wy_q + 1'b1;
            end
          end
        end
      end
    end
    if (clear) begin
      wy_d = '0;
      wx_d = '0;
      ch_d = '0;
      kr_d = '0;
      kc_d = '0;
    end
  end

  always_comb begin
    exhausted_d = (state_q == STREAM) ? exhausted_q : 1'b0;
    if (issue && frame_end) exhausted_d = 1'b1;
    if (clear) exhausted_d = 1'b0;

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    out_eof_d   = out_eof_q;
    if (issue) begin
      out_valid_d = 1'b1;
      out_data_d  = mem[rd_addr];
      out_first_d = (kr_q == '0) && (kc_q == '0);
      out_last_d  = ch_end && kr_end && kc_end;
      out_eof_d   = frame_end;
    end else if (accept) begin
      out_valid_d = 1'b0;
    end
    if (clear) begin
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_first_d = 1'b0;
      out_last_d  = 1'b0;
      out_eof_d   = 1'b0;
    end
  end

  always_comb begin
    busy = (state_q == STREAM);
    done = (state_q == DONE);
  end

  assign strm.out_valid = out_valid_q;
  assign strm.out_data  = out_data_q;
  assign strm.out_first = out_first_q;
  assign strm.out_last  = out_last_q;
  assign strm.out_eof   = out_eof_q;

endmodule

// File: tb/tb_window_streamer.sv
// Directed bench for window_streamer: a 5x5 K=3 S=1 C=1 instance and a
// 5x5 K=3 S=2 C=2 instance share stimulus, selected by sel.
module tb_window_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       go;
  logic       abort;
  logic       sel;
  logic       out_ready;
  logic       preEnA;
  logic       preEnB;
  logic [0:0] preCh;
  logic [4:0] preAddr;
  logic [7:0] prePix;
  logic       busyA, doneA, busyB, doneB;

  window_streamer_if #(.DATA_WIDTH(8)) ifA ();
  window_streamer_if #(.DATA_WIDTH(8)) ifB ();

  assign ifA.out_ready = out_ready;
  assign ifB.out_ready = out_ready;

  window_streamer #(
    .IMG_W(5), .IMG_H(5), .DATA_WIDTH(8), .KERNEL(3), .STRIDE(1), .CHANNELS(1)
  ) dutA (
    .clk(clk), .rst_n(rst_n), .clear(abort & ~sel),
    .preload_en(preEnA), .preload_ch(preCh), .preload_addr(preAddr), .preload_pixel(prePix),
    .start(go & ~sel), .busy(busyA), .done(doneA), .strm(ifA)
  );

  window_streamer #(
    .IMG_W(5), .IMG_H(5), .DATA_WIDTH(8), .KERNEL(3), .STRIDE(2), .CHANNELS(2)
  ) dutB (
    .clk(clk), .rst_n(rst_n), .clear(abort & sel),
    .preload_en(preEnB), .preload_ch(preCh), .preload_addr(preAddr), .preload_pixel(prePix),
    .start(go & sel), .busy(busyB), .done(doneB), .strm(ifB)
  );

  logic       obsValid, obsBusy, obsDone, obsEof;
  logic [7:0] obsData;
  logic [2:0] obsFlags;

  assign obsValid = sel ? ifB.out_valid : ifA.out_valid;
  assign obsData  = sel ? ifB.out_data  : ifA.out_data;
  assign obsEof   = sel ? ifB.out_eof   : ifA.out_eof;
  assign obsFlags = sel ? {ifB.out_first, ifB.out_last, ifB.out_eof}
                        : {ifA.out_first, ifA.out_last, ifA.out_eof};
  assign obsBusy  = sel ? busyB : busyA;
  assign obsDone  = sel ? doneB : doneA;

  int vectors = 0;
  int miscompares = 0;
  int expData [2][128];
  int expFlag [2][128];
  int expLen  [2];
  int capData [128];
  int handA   [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference order built straight from the nested window loops.
  task automatic buildExpected(input int idx, input int stride, input int chans);
    int ow, oh, n, a;
    ow = (5 - 3) / stride + 1;
    oh = (5 - 3) / stride + 1;
    n  = 0;
    for (int wy = 0; wy < oh; wy++)
      for (int wx = 0; wx < ow; wx++)
        for (int ch = 0; ch < chans; ch++)
          for (int kr = 0; kr < 3; kr++)
            for (int kc = 0; kc < 3; kc++) begin
              a = (wy * stride + kr) * 5 + wx * stride + kc;
              expData[idx][n] = (ch == 1) ? 100 + a : a;
              expFlag[idx][n] = ((kr == 0 && kc == 0) ? 4 : 0)
                              + ((ch == chans - 1 && kr == 2 && kc == 2) ? 2 : 0)
                              + ((ch == chans - 1 && kr == 2 && kc == 2
                                  && wy == oh - 1 && wx == ow - 1) ? 1 : 0);
              n++;
            end
    expLen[idx] = n;
  endtask

  task automatic preloadAll();
    for (int a = 0; a < 25; a++) begin
      @(posedge clk); #1;
      preEnA = 1'b1; preEnB = 1'b1; preCh = 1'b0;
      preAddr = 5'(a); prePix = 8'(a);
    end
    for (int a = 0; a < 25; a++) begin
      @(posedge clk); #1;
      preEnA = 1'b0; preEnB = 1'b1; preCh = 1'b1;
      preAddr = 5'(a); prePix = 8'(100 + a);
    end
    @(posedge clk); #1;
    preEnA = 1'b0; preEnB = 1'b0; preCh = 1'b0;
  endtask

  // Runs one frame on the selected instance; optionally meddles at beat 10
  // (preload 99 to address 0 plus a stray start) and aborts at beat abortAt.
  task automatic applyStimulus(input bit randomReady, input int abortAt,
                               input int abortKind, input bit meddle);
    int  idx, n, held, heldF;
    bit  stalled, eofSeen;
    idx = sel ? 1 : 0;
    n = 0; stalled = 1'b0; eofSeen = 1'b0; held = 0; heldF = 0;
    @(posedge clk); #1;
    go = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    checkOutput("busyAtT1", 32'(obsBusy), 1);
    checkOutput("validAtT1", 32'(obsValid), 1);
    for (int cyc = 0; cyc < 3000 && !eofSeen; cyc++) begin
      if (meddle) begin
        preEnA = (n == 10); go = (n == 10); preCh = 1'b0; preAddr = 5'd0; prePix = 8'd99;
      end
      if (stalled) begin
        checkOutput("stallValid", 32'(obsValid), 1);
        checkOutput("stallData", 32'(obsData), 32'(held));
        checkOutput("stallFlags", 32'(obsFlags), 32'(heldF));
      end
      if (!randomReady) checkOutput("noBubble", 32'(obsValid), 1);
      if (abortAt >= 0 && n == abortAt) begin
        preEnA = 1'b0; go = 1'b0;
        if (abortKind == 0) begin
          abort = 1'b1;
          @(posedge clk); #1;
          abort = 1'b0;
        end else begin
          rst_n = 1'b0;
          #1;
        end
        checkOutput("abortValid", 32'(obsValid), 0);
        checkOutput("abortData", 32'(obsData), 0);
        checkOutput("abortFlags", 32'(obsFlags), 0);
        checkOutput("abortBusy", 32'(obsBusy), 0);
        checkOutput("abortDone", 32'(obsDone), 0);
        if (abortKind != 0) begin
          #1 rst_n = 1'b1;
        end
        return;
      end
      out_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
      if (obsValid && out_ready) begin
        if (n < 128) begin
          capData[n] = 32'(obsData);
          checkOutput("beatData", 32'(obsData), 32'(expData[idx][n]));
          checkOutput("beatFlags", 32'(obsFlags), 32'(expFlag[idx][n]));
        end else begin
          checkOutput("beatOverrun", 32'(n), 32'(expLen[idx]));
        end
        if (obsEof) eofSeen = 1'b1;
        n++;
      end
      stalled = obsValid && !out_ready;
      held    = 32'(obsData);
      heldF   = 32'(obsFlags);
      @(posedge clk); #1;
    end
    preEnA = 1'b0; go = 1'b0; out_ready = 1'b1;
    checkOutput("eofSeen", 32'(eofSeen), 1);
    checkOutput("beatCount", 32'(n), 32'(expLen[idx]));
    checkOutput("doneAfterEof", 32'(obsDone), 1);
    checkOutput("busyAfterEof", 32'(obsBusy), 0);
    checkOutput("validAfterEof", 32'(obsValid), 0);
    @(posedge clk); #1;
    checkOutput("donePulseEnds", 32'(obsDone), 0);
  endtask

  initial begin
    rst_n = 1'b0; go = 1'b0; abort = 1'b0; sel = 1'b0; out_ready = 1'b1;
    preEnA = 1'b0; preEnB = 1'b0; preCh = 1'b0; preAddr = '0; prePix = '0;
    buildExpected(0, 1, 1);
    buildExpected(1, 2, 2);
    #12;
    checkOutput("rstValid", 32'(obsValid), 0);
    checkOutput("rstData", 32'(obsData), 0);
    checkOutput("rstFlags", 32'(obsFlags), 0);
    checkOutput("rstBusy", 32'(obsBusy), 0);
    checkOutput("rstDone", 32'(obsDone), 0);
    rst_n = 1'b1;
    preloadAll();

    $display("[TB] stride 1, single channel, ready held high");
    sel = 1'b0;
    applyStimulus(1'b0, -1, 0, 1'b0);
    for (int i = 0; i < 9; i++) checkOutput("firstWindow", 32'(capData[i]), 32'(handA[i]));
    checkOutput("finalBeat", 32'(capData[80]), 24);

    $display("[TB] stride 2, two channels");
    sel = 1'b1;
    applyStimulus(1'b0, -1, 0, 1'b0);
    for (int i = 0; i < 9; i++) checkOutput("win0Ch1", 32'(capData[9 + i]), 32'(100 + handA[i]));
    checkOutput("win1Start", 32'(capData[18]), 2);
    for (int i = 0; i < 9; i++) checkOutput("win3Ch0", 32'(capData[54 + i]), 32'(12 + handA[i]));

    $display("[TB] random backpressure");
    sel = 1'b0;
    applyStimulus(1'b1, -1, 0, 1'b0);

    $display("[TB] dropped preload, stray start, clear at beat 20, replay");
    applyStimulus(1'b0, 20, 0, 1'b1);
    applyStimulus(1'b0, -1, 0, 1'b0);

    $display("[TB] async reset at beat 20, replay");
    applyStimulus(1'b0, 20, 1, 1'b0);
    applyStimulus(1'b0, -1, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
